// File: rtl/decode_ex_skid.sv
// Two-entry skid buffer between decode and execute with registered in_ready and flush.
// Optional back-pressure statistics counter enabled by defining DEC_EX_STATS_EN.
module decode_ex_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [11:0]           in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [11:0]           out_ctrl,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_rs1,
  output logic [DATA_WIDTH-1:0] out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic [31:0]           stall_cnt
);
  localparam int ENTRY_W = 12 + 4 * DATA_WIDTH + ADDR_WIDTH;
  // Clears RegWrite(11), Branch(7), MemWrite(5) and J(1:0) during bubbles.
  localparam logic [11:0] BUBBLE_MASK = 12'h75C;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic [ENTRY_W-1:0]  in_entry;
  logic [ENTRY_W-1:0]  main_p0;
  logic [ENTRY_W-1:0]  skid_p0;
  logic [11:0]         ctrl_raw;
  logic                ready_p0;
  logic                vld_p0;
  logic                acc;
  logic                deq;

  assign in_entry = {in_ctrl, in_pc, in_rs1, in_rs2, in_imm, in_rd};
  assign vld_p0   = (state != EMPTY);
  assign acc      = in_valid & ready_p0;
  assign deq      = vld_p0 & out_ready;

  // Decode -> buffer boundary: main register feeds execute, skid absorbs one extra entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ready_p0 <= 1'b1;
      main_p0  <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      ready_p0 <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_p0 <= in_entry;
            state   <= ONE;
          end
          ready_p0 <= 1'b1;
        end
        ONE: begin
          if (acc && !deq) begin
            skid_p0  <= in_entry;
            state    <= FULL;
            ready_p0 <= 1'b0;
          end else if (acc && deq) begin
            main_p0  <= in_entry;
            ready_p0 <= 1'b1;
          end else if (deq) begin
            state    <= EMPTY;
            ready_p0 <= 1'b1;
          end
        end
        FULL: begin
          if (deq) begin
            main_p0  <= skid_p0;
            state    <= ONE;
            ready_p0 <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          ready_p0 <= 1'b1;
        end
      endcase
    end
  end

  assign {ctrl_raw, out_pc, out_rs1, out_rs2, out_imm, out_rd} = main_p0;
  assign out_ctrl  = vld_p0 ? ctrl_raw : (ctrl_raw & BUBBLE_MASK);
  assign out_valid = vld_p0;
  assign in_ready  = ready_p0;

`ifdef DEC_EX_STATS_EN
  logic [31:0] stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (vld_p0 && !out_ready) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_ex_skid.sv
// Directed self-checking bench for decode_ex_skid: reset, streaming, back-pressure, flush, bubble, stats.
module tb_decode_ex_skid;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_ctrl = 12'h000;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_ctrl;
  logic [31:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [4:0]  out_rd;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ex_skid #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_rd(out_rd),
    .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction fields are derived from pc so each entry is distinguishable.
  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = 12'hFFF - pc[11:0];
    in_rs1   = pc + 32'd100;
    in_rs2   = ~pc;
    in_imm   = pc << 1;
    in_rd    = pc[6:2];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL reset_ctrl got %h exp 000", out_ctrl); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      drive(1'b1, pc);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_pc !== pc) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, out_pc, pc); end
      checks++; if (out_ctrl !== 12'hFFF - pc[11:0]) begin errors++; $display("FAIL stream_ctrl[%0d] got %h exp %h", k, out_ctrl, 12'hFFF - pc[11:0]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", k, in_ready); end
    end
    checks++; if (out_rs1 !== 32'd112 || out_rs2 !== 32'hFFFF_FFF3 || out_imm !== 32'h18 || out_rd !== 5'd3) begin
      errors++; $display("FAIL stream_data got %h %h %h %h exp 70 fffffff3 18 03", out_rs1, out_rs2, out_imm, out_rd);
    end
    drive(1'b0, 32'h0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h10);
    step();
    checks++; if (out_pc !== 32'h10 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one got pc %h rdy %b exp 10 1", out_pc, in_ready); end
    drive(1'b1, 32'h14);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL bp_full_pc got %h exp 10", out_pc); end
    drive(1'b1, 32'h18);
    step();
    checks++; if (out_pc !== 32'h10 || out_ctrl !== 12'hFEF || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got pc %h ctrl %h rdy %b exp 10 fef 0", out_pc, out_ctrl, in_ready);
    end
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h14) begin errors++; $display("FAIL bp_second got v %b pc %h exp 1 14", out_valid, out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0 (0x18 must not appear)", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h20);
    step();
    drive(1'b1, 32'h24);
    step();
    drive(1'b1, 32'h28);
    in_ctrl = 12'hFFF;
    flush = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got v %b rdy %b exp 0 1", out_valid, in_ready); end
    checks++; if (out_ctrl[11] !== 1'b0 || out_ctrl[5] !== 1'b0) begin errors++; $display("FAIL flush_ctrl got %h exp RegWrite=MemWrite=0", out_ctrl); end
    drive(1'b1, 32'h2C);
    step();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h20) begin errors++; $display("FAIL flush_accept got v %b pc %h exp 0 20", out_valid, out_pc); end
    flush = 1'b0;
    drive(1'b0, 32'h0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b exp 0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_ctrl = 12'hFFF;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h75C) begin errors++; $display("FAIL bubble_idle got v %b ctrl %h exp 0 75c", out_valid, out_ctrl); end
    out_ready = 1'b0;
    drive(1'b1, 32'h30);
    in_ctrl = 12'hFFF;
    step();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 12'hFFF) begin errors++; $display("FAIL bubble_live got v %b ctrl %h exp 1 fff", out_valid, out_ctrl); end
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h75C || out_pc !== 32'h30) begin
      errors++; $display("FAIL bubble_mask got v %b ctrl %h pc %h exp 0 75c 30", out_valid, out_ctrl, out_pc);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp7, exp8;
`ifdef DEC_EX_STATS_EN
    exp7 = 32'd7;
    exp8 = 32'd8;
`else
    exp7 = 32'd0;
    exp8 = 32'd0;
`endif
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h40);
    step();
    drive(1'b0, 32'h0);
    for (int k = 0; k < 7; k++) step();
    checks++; if (stall_cnt !== exp7) begin errors++; $display("FAIL stats_7 got %0d exp %0d", stall_cnt, exp7); end
    checks++; if (out_pc !== 32'h40 || out_valid !== 1'b1) begin errors++; $display("FAIL stats_hold got pc %h v %b exp 40 1", out_pc, out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++; if (stall_cnt !== exp8) begin errors++; $display("FAIL stats_flush got %0d exp %0d", stall_cnt, exp8); end
    drive(1'b1, 32'h44);
    step();
    drive(1'b1, 32'h48);
    flush = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (stall_cnt !== 32'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stats_rst got cnt %0d v %b pc %h rdy %b exp 0 0 0 1", stall_cnt, out_valid, out_pc, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
